vram_blit_engine: RTL and testbench

- Hardware scroll/clear sequencer for the 80x30 text-mode VRAM: 1200 words x 32 bits, 2 glyph entries per word, 40 words per row.
- Shares VRAM port A with the Avalon-MM CPU path. The CPU always wins the port; the engine uses only idle cycles.
- Sits between the Avalon slave logic and the dual-port on-chip RAM inside the text-mode VGA interface. Port B (display scan-out) is untouched.

---
 rtl/vga_text_pkg.sv | 24 ++
 rtl/vram_blit_engine_if.sv | 43 ++++
 rtl/vram_port_mux.sv | 41 ++++
 rtl/vram_blit_engine.sv | 137 +++++++++++++
 tb/tb_vram_blit_engine.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared geometry, opcodes and sequencer states for the text VRAM blitter
package vga_text_pkg;

  localparam int ROWS       = 30;
  localparam int ROW_WORDS  = 40;
  localparam int VRAM_WORDS = 1200;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_SCROLL   = 2'b01,
    OP_CLEAR    = 2'b10,
    OP_FILL_ROW = 2'b11
  } blit_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RWAIT = 3'd2,
    WR    = 3'd3,
    FILL  = 3'd4,
    FIN   = 3'd5
  } blit_state_t;

endpackage

// File: rtl/vram_blit_engine_if.sv
// rtl/vram_blit_engine_if.sv - CPU, command and VRAM port-A signal bundle of the blit engine
interface vram_blit_engine_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              AVL_CS;
  logic              AVL_READ;
  logic              AVL_WRITE;
  logic [ADDR_W-1:0] AVL_ADDR;
  logic [3:0]        AVL_BYTE_EN;
  logic [DATA_W-1:0] AVL_WRITEDATA;

  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic [4:0]        CMD_ROW;
  logic [DATA_W-1:0] CMD_FILL;

  logic              BUSY;
  logic              DONE;
  logic              ERR;

  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [3:0]        MEM_BYTE_EN;
  logic              MEM_RDEN;
  logic              MEM_WREN;
  logic [DATA_W-1:0] MEM_RDATA;

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
    input  CMD_VALID, CMD_OP, CMD_ROW, CMD_FILL, MEM_RDATA,
    output CMD_READY, BUSY, DONE, ERR,
    output MEM_ADDR, MEM_WDATA, MEM_BYTE_EN, MEM_RDEN, MEM_WREN
  );

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
    output CMD_VALID, CMD_OP, CMD_ROW, CMD_FILL, MEM_RDATA,
    input  CMD_READY, BUSY, DONE, ERR,
    input  MEM_ADDR, MEM_WDATA, MEM_BYTE_EN, MEM_RDEN, MEM_WREN
  );
endinterface

// File: rtl/vram_port_mux.sv
// rtl/vram_port_mux.sv - combinational VRAM port-A select; the CPU always wins over the engine
module vram_port_mux #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              cpu_cs,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_byte_en,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              eng_rden,
  input  logic              eng_wren,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_byte_en,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic              cpu_grant
);

  always_comb begin
    cpu_grant = cpu_cs & (cpu_read | cpu_write);
    if (cpu_grant) begin
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
      mem_byte_en = cpu_byte_en;
      mem_rden    = cpu_read;
      mem_wren    = cpu_write;
    end else begin
      mem_addr    = eng_addr;
      mem_wdata   = eng_wdata;
      mem_byte_en = 4'hF;
      mem_rden    = eng_rden;
      mem_wren    = eng_wren;
    end
  end

endmodule

// File: rtl/vram_blit_engine.sv
// rtl/vram_blit_engine.sv - scroll/clear/fill-row sequencer using idle cycles of VRAM port A
module vram_blit_engine #(
  parameter int ROWS      = 30,
  parameter int ROW_WORDS = 40,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32
) (
  input logic               CLK,
  input logic               RESET,
  vram_blit_engine_if.slave bus
);
  import vga_text_pkg::*;

  localparam logic [ADDR_W-1:0] COPY_END = ADDR_W'((ROWS - 1) * ROW_WORDS);
  localparam logic [ADDR_W-1:0] LAST_END = ADDR_W'(ROWS * ROW_WORDS);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_WORDS);

  blit_state_t       state_q, state_d;
  logic [ADDR_W-1:0] dst_q, dst_d, end_q, end_d;
  logic [DATA_W-1:0] hold_q, hold_d, fill_q, fill_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] row_base, dst_inc, eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              eng_rden, eng_wren, cpu_grant;

  assign row_base = ADDR_W'(bus.CMD_ROW) * ROW_STEP;
  assign dst_inc  = dst_q + ADDR_W'(1);

  vram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .cpu_cs      (bus.AVL_CS),
    .cpu_read    (bus.AVL_READ),
    .cpu_write   (bus.AVL_WRITE),
    .cpu_addr    (bus.AVL_ADDR),
    .cpu_byte_en (bus.AVL_BYTE_EN),
    .cpu_wdata   (bus.AVL_WRITEDATA),
    .eng_rden    (eng_rden),
    .eng_wren    (eng_wren),
    .eng_addr    (eng_addr),
    .eng_wdata   (eng_wdata),
    .mem_addr    (bus.MEM_ADDR),
    .mem_wdata   (bus.MEM_WDATA),
    .mem_byte_en (bus.MEM_BYTE_EN),
    .mem_rden    (bus.MEM_RDEN),
    .mem_wren    (bus.MEM_WREN),
    .cpu_grant   (cpu_grant)
  );

  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    end_d     = end_q;
    hold_d    = hold_q;
    fill_d    = fill_q;
    err_d     = err_q;
    eng_rden  = 1'b0;
    eng_wren  = 1'b0;
    eng_addr  = dst_q;
    eng_wdata = fill_q;
    case (state_q)
      IDLE: begin
        if (bus.CMD_VALID) begin
          fill_d = bus.CMD_FILL;
          err_d  = 1'b0;
          dst_d  = '0;
          end_d  = LAST_END;
          case (blit_op_t'(bus.CMD_OP))
            OP_SCROLL: state_d = RD;
            OP_CLEAR:  state_d = FILL;
            OP_FILL_ROW: begin
              if (ADDR_W'(bus.CMD_ROW) >= ADDR_W'(ROWS)) begin
                err_d   = 1'b1;
                state_d = FIN;
              end else begin
                dst_d   = row_base;
                end_d   = row_base + ROW_STEP;
                state_d = FILL;
              end
            end
            default: state_d = FIN;
          endcase
        end
      end
      RD: begin
        eng_rden = 1'b1;
        eng_addr = dst_q + ROW_STEP;
        if (!cpu_grant) state_d = RWAIT;
      end
      // Read data arrives here whether or not the CPU owns the port this cycle.
      RWAIT: begin
        hold_d  = bus.MEM_RDATA;
        state_d = WR;
      end
      WR: begin
        eng_wren  = 1'b1;
        eng_wdata = hold_q;
        if (!cpu_grant) begin
          dst_d   = dst_inc;
          state_d = (dst_inc < COPY_END) ? RD : FILL;
        end
      end
      FILL: begin
        eng_wren = 1'b1;
        if (!cpu_grant) begin
          dst_d = dst_inc;
          if (!(dst_inc < end_q)) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      dst_q   <= '0;
      end_q   <= '0;
      hold_q  <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      end_q   <= end_d;
      hold_q  <= hold_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  assign bus.CMD_READY = (state_q == IDLE);
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.DONE      = (state_q == FIN);
  assign bus.ERR       = (state_q == FIN) & err_q;

endmodule

// File: tb/tb_vram_blit_engine.sv
// tb/tb_vram_blit_engine.sv - table-driven, scoreboard-checked bench for vram_blit_engine
module tb_vram_blit_engine;
  import vga_text_pkg::*;

  localparam int N = 1200;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [4:0]  row;
    logic [31:0] fill;
    int          cpu_mode;
    bit          preload;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  typedef struct {
    int lat;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  vram_blit_engine_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  vram_blit_engine #(.ROWS(30), .ROW_WORDS(40), .ADDR_W(11), .DATA_W(32)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  logic [31:0] ram     [N];
  logic [31:0] exp_mem [N];
  logic        do_preload = 1'b0;
  exp_t        sb[$];
  vec_t        vecs[7];
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) begin
    if (do_preload) begin
      for (int k = 0; k < N; k++) ram[k] <= 32'(k);
    end else begin
      if (bus.MEM_WREN && int'(bus.MEM_ADDR) < N)
        for (int b = 0; b < 4; b++)
          if (bus.MEM_BYTE_EN[b]) ram[int'(bus.MEM_ADDR)][8*b +: 8] <= bus.MEM_WDATA[8*b +: 8];
      if (bus.MEM_RDEN && int'(bus.MEM_ADDR) < N) bus.MEM_RDATA <= ram[int'(bus.MEM_ADDR)];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cpu_idle();
    bus.AVL_CS = 1'b0;
    bus.AVL_READ = 1'b0;
    bus.AVL_WRITE = 1'b0;
    bus.AVL_ADDR = '0;
    bus.AVL_BYTE_EN = 4'h0;
    bus.AVL_WRITEDATA = '0;
  endtask

  // mode 1: ten CPU writes at cycles 100..109; mode 2: CPU read held for cycles 10..14
  task automatic cpu_drive(input int mode, input int cyc);
    cpu_idle();
    if (mode == 1 && cyc >= 100 && cyc < 110) begin
      bus.AVL_CS = 1'b1;
      bus.AVL_WRITE = 1'b1;
      bus.AVL_BYTE_EN = 4'hF;
      bus.AVL_ADDR = (cyc < 105) ? 11'(cyc - 100) : 11'(1100 + cyc - 105);
      bus.AVL_WRITEDATA = 32'hC0DE_0000 + 32'(cyc - 100);
    end else if (mode == 2 && cyc >= 10 && cyc < 15) begin
      bus.AVL_CS = 1'b1;
      bus.AVL_READ = 1'b1;
    end
  endtask

  task automatic model_apply(input vec_t v);
    case (v.op)
      2'b01: begin
        for (int i = 0; i < 1160; i++) exp_mem[i] = exp_mem[i + 40];
        for (int i = 1160; i < N; i++) exp_mem[i] = v.fill;
      end
      2'b10: begin
        for (int i = 0; i < N; i++) exp_mem[i] = v.fill;
        if (v.cpu_mode == 1)
          for (int i = 0; i < 5; i++) exp_mem[i] = 32'hC0DE_0000 + 32'(i);
      end
      2'b11: if (int'(v.row) < 30)
        for (int i = 0; i < 40; i++) exp_mem[int'(v.row) * 40 + i] = v.fill;
      default: ;
    endcase
  endtask

  task automatic compare_image(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < N; i++)
      if (ram[i] !== exp_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_image words_wrong=%0d first=%0d actual=%0h required=%0h",
               name, bad, first, ram[first], exp_mem[first]);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int   cyc = 0;
    bit   seen = 1'b0;
    bit   wren_seen = 1'b0;
    exp_t e;
    @(negedge clk);
    if (v.preload) begin
      do_preload = 1'b1;
      for (int k = 0; k < N; k++) exp_mem[k] = 32'(k);
      @(negedge clk);
      do_preload = 1'b0;
    end
    check({v.name, "_ready"}, 32'(bus.CMD_READY), 32'd1);
    bus.CMD_OP = v.op;
    bus.CMD_ROW = v.row;
    bus.CMD_FILL = v.fill;
    bus.CMD_VALID = 1'b1;
    @(posedge clk);
    sb.push_back('{v.exp_lat, v.exp_err});
    model_apply(v);
    while (!seen && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.CMD_VALID = 1'b0;
        check({v.name, "_busy"}, 32'(bus.BUSY), 32'd1);
      end
      if (bus.DONE) begin
        seen = 1'b1;
        e = sb.pop_front();
        check({v.name, "_latency"}, 32'(cyc), 32'(e.lat));
        check({v.name, "_err"}, 32'(bus.ERR), 32'(e.err));
      end
      cpu_drive(v.cpu_mode, cyc);
      #1;
      if (bus.MEM_WREN) wren_seen = 1'b1;
    end
    cpu_idle();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_5000", v.name);
      sb.delete();
    end
    if (v.exp_err) check({v.name, "_no_write"}, 32'(wren_seen), 32'd0);
    compare_image(v.name);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{"scroll",     2'b01, 5'd0,  32'h2020_2020, 0, 1'b1, 3521, 1'b0};
    vecs[1] = '{"fill_r29",   2'b11, 5'd29, 32'hA5A5_A5A5, 0, 1'b0, 41,   1'b0};
    vecs[2] = '{"fill_r31",   2'b11, 5'd31, 32'hDEAD_BEEF, 0, 1'b0, 1,    1'b1};
    vecs[3] = '{"nop",        2'b00, 5'd0,  32'h1111_1111, 0, 1'b0, 1,    1'b0};
    vecs[4] = '{"fill_r0",    2'b11, 5'd0,  32'h1234_5678, 0, 1'b0, 41,   1'b0};
    vecs[5] = '{"clear_cpu",  2'b10, 5'd0,  32'h0000_0000, 1, 1'b0, 1211, 1'b0};
    vecs[6] = '{"scroll_rds", 2'b01, 5'd0,  32'h4141_4141, 2, 1'b1, 3526, 1'b0};

    cpu_idle();
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP = 2'b00;
    bus.CMD_ROW = '0;
    bus.CMD_FILL = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(bus.BUSY),      32'd0);
    check("rst_done",  32'(bus.DONE),      32'd0);
    check("rst_err",   32'(bus.ERR),       32'd0);
    check("rst_ready", 32'(bus.CMD_READY), 32'd1);
    check("rst_wren",  32'(bus.MEM_WREN),  32'd0);
    check("rst_rden",  32'(bus.MEM_RDEN),  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Reset in the middle of a scroll must drop the engine off the port at once.
    @(negedge clk);
    do_preload = 1'b1;
    @(negedge clk);
    do_preload = 1'b0;
    bus.CMD_OP = 2'b01;
    bus.CMD_FILL = 32'h2020_2020;
    bus.CMD_VALID = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      bus.CMD_VALID = 1'b0;
    end
    check("mid_busy_before", 32'(bus.BUSY), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy",  32'(bus.BUSY),     32'd0);
    check("abort_wren",  32'(bus.MEM_WREN), 32'd0);
    check("abort_done",  32'(bus.DONE),     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.CMD_READY), 32'd1);
    v = '{"clear_after_rst", 2'b10, 5'd0, 32'h7777_7777, 0, 1'b0, 1201, 1'b0};
    run_cmd(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
